// File: rtl/mod_pingpong_ctrl.sv
`default_nettype none
//==============================================================================
// mod_pingpong_ctrl - two-bank ping-pong symbol buffer control, mapper -> DFT (rev 1.0)
//==============================================================================
module mod_pingpong_ctrl #(
   parameter int ADDR_W  = 11,
   parameter int SYM_MAX = 1200
) (
   input  logic              CLK_Mod,
   input  logic              RST_Mod,
   input  logic              sym_valid,
   input  logic              sym_last,
   output logic              wr_stall,
   output logic [1:0]        ram_we,
   output logic [ADDR_W-1:0] ram_waddr,
   output logic [1:0]        ram_re,
   output logic [ADDR_W-1:0] ram_raddr,
   input  logic              rd_ready,
   output logic              rd_valid,
   output logic              rd_last,
   output logic [ADDR_W-1:0] rd_len,
   output logic [1:0]        bank_full,
   output logic              overflow_err
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FILL  = 2'd1,
      FULL  = 2'd2,
      DRAIN = 2'd3
   } bank_st_t;

   localparam logic [ADDR_W-1:0] WCNT_LAST = ADDR_W'(SYM_MAX - 1);
   localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

   bank_st_t          st_q   [2];
   bank_st_t          st_d   [2];
   logic [ADDR_W-1:0] len_q  [2];
   logic [ADDR_W-1:0] len_d  [2];
   logic              wr_bank_q, wr_bank_d;
   logic              rd_bank_q, rd_bank_d;
   logic [ADDR_W-1:0] wcnt_q, wcnt_d;
   logic [ADDR_W-1:0] rcnt_q, rcnt_d;
   logic [ADDR_W-1:0] rd_len_q, rd_len_d;
   logic              rd_valid_q, rd_last_q, ovf_q;
   logic              accept, wr_close, issue;

   always_ff @(posedge CLK_Mod or negedge RST_Mod) begin
      if (!RST_Mod) begin
         st_q[0]    <= EMPTY;
         st_q[1]    <= EMPTY;
         len_q[0]   <= '0;
         len_q[1]   <= '0;
         wr_bank_q  <= 1'b0;
         rd_bank_q  <= 1'b0;
         wcnt_q     <= '0;
         rcnt_q     <= '0;
         rd_len_q   <= '0;
         rd_valid_q <= 1'b0;
         rd_last_q  <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         st_q       <= st_d;
         len_q      <= len_d;
         wr_bank_q  <= wr_bank_d;
         rd_bank_q  <= rd_bank_d;
         wcnt_q     <= wcnt_d;
         rcnt_q     <= rcnt_d;
         rd_len_q   <= rd_len_d;
         rd_valid_q <= issue;
         rd_last_q  <= issue && (rcnt_q == rd_len_q - ONE);
         ovf_q      <= ovf_q | (sym_valid & wr_stall);
      end
   end

   always_comb begin
      st_d      = st_q;
      len_d     = len_q;
      wr_bank_d = wr_bank_q;
      rd_bank_d = rd_bank_q;
      wcnt_d    = wcnt_q;
      rcnt_d    = rcnt_q;
      rd_len_d  = rd_len_q;
      ram_we    = 2'b00;
      ram_re    = 2'b00;

      wr_stall = (st_q[wr_bank_q] == FULL) || (st_q[wr_bank_q] == DRAIN);
      // Reset gates the write strobe so no RAM write leaks out while held in reset.
      accept   = sym_valid && !wr_stall && RST_Mod;
      wr_close = (accept && ((wcnt_q == WCNT_LAST) || sym_last)) ||
                 (!sym_valid && sym_last && (wcnt_q != '0));
      issue    = (st_q[rd_bank_q] == DRAIN) && rd_ready && (rcnt_q != rd_len_q);

      if (accept) begin
         ram_we[wr_bank_q] = 1'b1;
      end

      if (wr_close) begin
         len_d[wr_bank_q] = accept ? (wcnt_q + ONE) : wcnt_q;
         st_d[wr_bank_q]  = FULL;
         wr_bank_d        = ~wr_bank_q;
         wcnt_d           = '0;
      end else if (accept) begin
         wcnt_d = wcnt_q + ONE;
         if (st_q[wr_bank_q] == EMPTY) begin
            st_d[wr_bank_q] = FILL;
         end
      end

      // The bank is released on the edge that ends the rd_last cycle.
      if (st_q[rd_bank_q] == FULL) begin
         st_d[rd_bank_q] = DRAIN;
         rcnt_d          = '0;
         rd_len_d        = len_q[rd_bank_q];
      end else if (rd_last_q) begin
         st_d[rd_bank_q] = EMPTY;
         rd_bank_d       = ~rd_bank_q;
      end else if (issue) begin
         ram_re[rd_bank_q] = 1'b1;
         rcnt_d            = rcnt_q + ONE;
      end
   end

   for (genvar b = 0; b < 2; b++) begin : g_bank_full
      assign bank_full[b] = (st_q[b] == FULL) || (st_q[b] == DRAIN);
   end

   assign ram_waddr    = wcnt_q;
   assign ram_raddr    = rcnt_q;
   assign rd_valid     = rd_valid_q;
   assign rd_last      = rd_last_q;
   assign rd_len       = rd_len_q;
   assign overflow_err = ovf_q;

endmodule
`default_nettype wire

// File: doc/mod_pingpong_ctrl.md
Name: mod_pingpong_ctrl

Overview:
- Ping-pong symbol-buffer controller between the modulation mapper and the downstream transform-precoding (DFT) stage.
- Steers mapper output symbols into one of two 1200-entry RAM banks and closes a bank on a full OFDM symbol or on an end-of-block marker.
- Drains full banks in order to the DFT stage, and stalls the mapper when both banks are occupied.

Parameters:
- ADDR_W, 11, RAM address width per bank.
- SYM_MAX, 1200, maximum symbols per bank (one PUSCH OFDM symbol, 100 PRB).

Ports:
- CLK_Mod  in  1  clock.
- RST_Mod  in  1  reset, asynchronous, active-low.
- sym_valid  in  1  mapper symbol present this cycle.
- sym_last  in  1  end of codeword; may accompany sym_valid or arrive alone.
- wr_stall  out  1  mapper must hold its symbol; combinational from registered bank state.
- ram_we  out  2  per-bank write enable, one-hot or zero.
- ram_waddr  out  ADDR_W  write address.
- ram_re  out  2  per-bank read enable.
- ram_raddr  out  ADDR_W  read address.
- rd_ready  in  1  DFT stage requests next sample.
- rd_valid  out  1  RAM data valid on the RAM output (1-cycle sync RAM).
- rd_last  out  1  with rd_valid on the final sample of a bank.
- rd_len  out  ADDR_W  length of the bank being drained; held during drain.
- bank_full  out  2  bank state is FULL or DRAIN.
- overflow_err  out  1  sticky; set on sym_valid while wr_stall.

Behaviour:
- Reset values: all outputs 0; both banks EMPTY; wr_bank=0, rd_bank=0; write count 0; len registers 0.
- Per-bank state encoding: EMPTY, FILL, FULL, DRAIN.

Write side:
- wr_stall = (state[wr_bank] == FULL or DRAIN).
- Accept: sym_valid & !wr_stall.
  - Same cycle: ram_we[wr_bank]=1, ram_waddr=wcnt.
  - Next edge: wcnt+1; bank enters FILL if EMPTY.
- Close condition, evaluated on the accepting edge: (wcnt == SYM_MAX-1) or sym_last. On close:
  - len[wr_bank] = wcnt+1; state FULL.
  - wr_bank toggles; wcnt = 0.
- sym_last alone (no sym_valid):
  - wcnt>0: close with len = wcnt.
  - wcnt == 0: ignored.
- sym_valid while stalled: no write, no count change, overflow_err = 1 until reset.
- Wrap-around: wcnt never exceeds SYM_MAX-1; a 1201st symbol goes to the other bank at address 0.

Read side:
- When state[rd_bank] == FULL: next edge → DRAIN, rcnt=0, rd_len = len[rd_bank].
- In DRAIN with rd_ready=1:
  - ram_re[rd_bank]=1, ram_raddr=rcnt, rcnt+1.
  - rd_valid registered one cycle later.
  - rd_ready=0 pauses issue; rd_valid drops in the following cycle.
- rd_ready is a request, not a ready/valid backpressure: data already issued is always delivered.
- rd_last is asserted with the rd_valid of address rd_len-1. On that edge:
  - state[rd_bank] = EMPTY; rd_bank toggles.
  - If the other bank is FULL, its drain starts on the next edge.
- Latency: from close to first ram_re is at least 2 cycles (FULL→DRAIN, then issue).

Simultaneous events:
- Close of one bank and free of the other in the same edge: both take effect.
- A bank freed on edge N accepts writes from cycle N+1; wr_stall is evaluated from registered state, so it is still high in cycle N.
- sym_last together with the SYM_MAX-1 write: single close, len=SYM_MAX.
- Reset mid-operation: immediate clear, partial buffer contents discarded, overflow_err cleared.

Arithmetic:
- Counters ADDR_W unsigned.
- No symbol data passes through the block; it carries addresses and control only.

Test Plan:
- 1200 consecutive sym_valid, rd_ready=1 → bank0 closes with len=1200 at the 1200th write; wr_bank=1; ram_re[0] first asserted 2 cycles later; rd_last on the 1200th rd_valid; bank0 returns EMPTY.
- 300 symbols with sym_last on the 300th, then 500 symbols with sym_last → rd_len=300 for bank0, then 500 for bank1; rd_last at addresses 299 and 499.
- rd_ready=0 while writing 2400 symbols → wr_stall rises after the 2400th write; a 2401st sym_valid sets overflow_err=1 and ram_we stays 0; after rd_ready=1 and bank0 drains, wr_stall falls the cycle after bank0's rd_last.
- rd_ready toggling 1/0 each cycle during a 10-entry drain → exactly 10 rd_valid pulses, ram_raddr 0..9 in order, no duplicates.
- sym_last alone with wcnt=0 → no state change; sym_last alone with wcnt=7 → close with len=7.
- RST_Mod low mid-drain at rcnt=500 → all outputs 0 asynchronously, both banks EMPTY; the next write goes to bank0 at address 0.
